// File: rtl/mms_stream.sv
// Streaming frame max/min selector: tracks the extreme of COUNT serial samples and
// pulses the winner and its index. Define MMS_SIGNED_EN for two's-complement compares.
module mms_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             select,
  input  logic [WIDTH-1:0] number,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [IDX_W-1:0] index
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             mode_q, mode_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDX_W-1:0] index_q, index_d;

  logic accept;
  logic greater;
  logic less;
  logic better;

  assign accept = in_valid & in_ready_q;

  // Strict compare so the earliest of equal extremes is kept
`ifdef MMS_SIGNED_EN
  assign greater = $signed(number) > $signed(best_q);
  assign less    = $signed(number) < $signed(best_q);
`else
  assign greater = number > best_q;
  assign less    = number < best_q;
`endif
  assign better = mode_q ? less : greater;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    mode_d      = mode_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    index_d     = index_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          best_d     = number;
          best_idx_d = '0;
          mode_d     = select;
          cnt_d      = CNT_W'(1);
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (better) begin
            best_d     = number;
            best_idx_d = cnt_q[IDX_W-1:0];
          end
          cnt_d = cnt_q + CNT_W'(1);
          // Last sample: publish the final extreme together with the pulse
          if (cnt_q == LAST_CNT) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = best_d;
            index_d     = best_idx_d;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      index_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      index_q     <= index_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign index     = index_q;

endmodule

// File: doc/mms_stream.md
Name: mms_stream

Overview:
- Sequential, parametrised successor to the combinational 8-number max/min selector.
- Accepts a frame of COUNT unsigned numbers serially over a valid/ready handshake and tracks the running max (select=0) or min (select=1).
- Emits the winning value and its position in the frame as a one-cycle result pulse.
- Sits between a sample source and any downstream consumer that needs the frame extreme without storing all samples in parallel.

Parameters:
- WIDTH, 8, bit width of each number and of result.
- COUNT, 8, numbers per frame; legal range 2..256.
- IDX_W, 3, width of index; must satisfy 2^IDX_W >= COUNT.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  number is valid this cycle.
- in_ready  output  1  block can accept a number this cycle.
- select  input  1  0 = max, 1 = min; sampled only with the first number of a frame.
- number  input  WIDTH  incoming sample.
- out_valid  output  1  one-cycle pulse; result/index valid.
- result  output  WIDTH  frame max/min.
- index  output  IDX_W  0-based position in the frame of the winning sample.

Behaviour:
- Accept rule: a sample is accepted on a rising edge where in_valid=1 and in_ready=1.
  - in_valid=0 stalls with no state change.
  - Gaps between samples are allowed.
- States:
  - IDLE: no frame open; in_ready=1.
  - ACCUM: frame open; in_ready=1.
  - DONE: in_ready=0; lasts exactly one cycle.
- IDLE transitions, on accept:
  - best <= number, best_idx <= 0, mode <= select, cnt <= 1; go to ACCUM.
- ACCUM transitions, on accept:
  - Compare number with best:
    - mode=0: replace best/best_idx if number > best.
    - mode=1: replace best/best_idx if number < best.
  - best_idx gets the current cnt value on replacement.
  - cnt <= cnt + 1.
  - When the accepted sample is the COUNT-th, go to DONE.
- DONE:
  - out_valid=1; result=best, index=best_idx (registered outputs).
  - Next cycle: state IDLE, out_valid=0.
- Latency: out_valid asserts the cycle immediately after the edge that accepts the last sample.
  - Minimum frame period is COUNT+1 cycles (one dead cycle in DONE).
- Ties: strict compare, so the earliest index among equal extremes wins.
- select is ignored after the first sample; toggling it mid-frame has no effect.
- result and index hold their last value after out_valid drops until the next DONE.
- Arithmetic: unsigned WIDTH-bit compare, no overflow possible.
  - cnt is IDX_W+1 bits so it can hold COUNT without wrap.
- Reset (any state, including mid-frame):
  - state=IDLE, cnt=0, best=0, best_idx=0, mode=0.
  - out_valid=0, result=0, index=0, in_ready=1 on the cycle after reset is sampled.
  - A partial frame is discarded.
  - reset wins over a simultaneous accept.
- COUNT=2 boundary: IDLE, then ACCUM for one sample, then DONE.

Optional Feature:
- Macro: MMS_SIGNED_EN.
  - Defined: number, result and internal best are two's complement; compares are signed. For example, 8'hFF (-1) is less than 8'h01.
  - Undefined: unsigned compare as above. For example, 8'hFF is greater than 8'h01.
- Handshake, timing and reset are identical in both builds.

Test Plan:
- Max frame: WIDTH=8, COUNT=8, select=0, numbers 3,17,9,200,4,200,0,55 back-to-back.
  - Expect out_valid one cycle after the 8th accept, with result=200, index=3 (tie keeps earliest).
  - in_ready=0 during that cycle.
- Min frame with gaps: select=1, numbers 90,12,77,12,5,250,5,40, with in_valid low for 2 cycles between samples.
  - Expect result=5, index=4, exactly one out_valid pulse.
- Mid-frame select toggle: frame starts with select=0, select flips to 1 after sample 2, numbers 1..8 ascending.
  - Expect result=8, index=7 (mode latched as max).
- Reset mid-frame: feed 5 samples, assert reset 1 cycle, then a full frame 10,20,30,40,50,60,70,80 with select=1.
  - Expect no out_valid before the new frame completes, then result=10, index=0.
  - All outputs read 0 the cycle after reset.
- Back-to-back frames: two consecutive max frames with in_valid held high.
  - Expect the 9th-cycle sample blocked (in_ready=0 in DONE), the second frame starting the following cycle, and two distinct out_valid pulses 9 cycles apart.
- Signed build (MMS_SIGNED_EN), select=0, numbers 8'h80,8'hFF,8'h7F,8'h00,8'h81,8'hFE,8'h01,8'h80.
  - Expect result=8'h7F, index=2.
  - Unsigned build with the same stimulus: expect result=8'hFF, index=1.
